// File: rtl/motor_passo_pkg.sv
// Shared constants for the MotorPasso stepper sequencer: register map,
// CTRL bit positions, FSM state type and the coil phase table.
package motor_passo_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STEPS  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_HALF   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned STATUS_POS_CLR = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Entry 0 sits in the least-significant nibble.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/motor_passo_step_ctrl_if.sv
// Avalon-MM slave bus bundle for the MotorPasso stepper sequencer.
interface motor_passo_step_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/motor_passo_step_timer.sv
// Step-period down-counter: load to PERIOD-1, count while enabled, and
// pulse tick on the cycle it sits at zero; a PERIOD of 0 acts as 1.
module motor_passo_step_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] reload_val;

  assign reload_val = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick       = en && !load && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = reload_val;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? reload_val : cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_passo_step_ctrl.sv
// Memory-mapped stepper sequencer: full/half-step coil patterns at a
// programmable rate, sticky DONE interrupt. Optional macro STEP_POSITION_EN.
module motor_passo_step_ctrl
  import motor_passo_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  motor_passo_step_ctrl_if.slave  bus,
  output logic                    irq,
  output logic [3:0]              coils
);

  state_e              state_q, state_d;
  logic [3:0]          ctrl_q, ctrl_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [2:0]          index_q, index_d;
  logic                done_q, done_d;
  logic [3:0]          coils_q, coils_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [15:0]         status_hi;

  logic               wr, wr_ctrl, wr_period, wr_steps, wr_status;
  logic [COUNT_W-1:0] steps_wdata;
  logic               running, abort, tick, step, set_done, timer_load;
  logic [2:0]         step_delta, next_index;
  logic               unused_wdata;

  assign wr          = bus.chipselect && !bus.write_n;
  assign wr_ctrl     = wr && (bus.address == ADDR_CTRL);
  assign wr_period   = wr && (bus.address == ADDR_PERIOD);
  assign wr_steps    = wr && (bus.address == ADDR_STEPS);
  assign wr_status   = wr && (bus.address == ADDR_STATUS);
  assign steps_wdata = bus.writedata[COUNT_W-1:0];
  assign unused_wdata = ^bus.writedata;

  assign running = (state_q == ST_RUN);
  // An abort in the same cycle as a timer tick suppresses that step entirely.
  assign abort = running &&
                 ((wr_steps && steps_wdata == '0) || (wr_ctrl && !bus.writedata[CTRL_EN]));
  assign step  = running && tick && !abort;

  assign step_delta = ctrl_q[CTRL_HALF] ? 3'd1 : 3'd2;
  assign next_index = ctrl_q[CTRL_DIR] ? index_q - step_delta : index_q + step_delta;

  motor_passo_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .en     (running),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    done_d      = done_q;
    set_done    = 1'b0;
    timer_load  = 1'b0;

    if (wr_ctrl)   ctrl_d   = bus.writedata[3:0];
    if (wr_period) period_d = bus.writedata[PERIOD_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (wr_steps) begin
          remaining_d = steps_wdata;
          if (steps_wdata != '0 && ctrl_q[CTRL_EN]) begin
            state_d    = ST_RUN;
            timer_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else begin
          if (step) begin
            index_d     = next_index;
            remaining_d = remaining_q - COUNT_W'(1);
          end
          // A nonzero STEPS reload overrides the decrement and keeps the move alive.
          if (wr_steps) begin
            remaining_d = steps_wdata;
          end else if (step && remaining_q == COUNT_W'(1)) begin
            state_d  = ST_IDLE;
            set_done = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (set_done)       done_d = 1'b1;
    else if (wr_status) done_d = 1'b0;

    coils_d = ctrl_d[CTRL_EN] ? phase_of(index_d) : 4'b0000;
  end

`ifdef STEP_POSITION_EN
  logic [15:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (step) begin
      pos_d = ctrl_q[CTRL_DIR] ? pos_q - 16'd1 : pos_q + 16'd1;
    end
    if (wr_status && bus.writedata[STATUS_POS_CLR]) begin
      pos_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign status_hi = pos_q;
`else
  assign status_hi = '0;
`endif

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_CTRL:   readdata_d = 32'({running, ctrl_q});
      ADDR_PERIOD: readdata_d = 32'(period_q);
      ADDR_STEPS:  readdata_d = 32'(remaining_q);
      ADDR_STATUS: readdata_d = {status_hi, 15'd0, done_q};
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      period_q    <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      done_q      <= 1'b0;
      coils_q     <= '0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      done_q      <= done_d;
      coils_q     <= coils_d;
      readdata_q  <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign coils        = coils_q;
  assign irq          = done_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_motor_passo_step_ctrl.sv
// Bench for motor_passo_step_ctrl: event-time reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_motor_passo_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       irq;
  logic [3:0] coils;

  motor_passo_step_ctrl_if bus_if ();

  motor_passo_step_ctrl #(.PERIOD_W(24), .COUNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .irq   (irq),
    .coils (coils)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a move is a list of step instants spaced max(PERIOD,1) apart.
  logic [3:0]  ph [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};
  bit          m_valid = 0;
  int          m_cyc = 0;
  int          m_next;
  logic [3:0]  m_ctrl;
  logic [23:0] m_period;
  int          m_rem;
  bit          m_busy, m_done;
  int          m_idx;
  logic [15:0] m_pos;
  logic [31:0] m_rd;
  logic [3:0]  m_coils;

  always @(posedge clk) begin
    bit          wr, step, abort, set_done;
    int          eff, d;
    logic [15:0] sval;
    logic [15:0] hi;
    m_cyc++;
    if (reset) begin
      m_valid = 1; m_ctrl = 0; m_period = 0; m_rem = 0; m_busy = 0; m_done = 0;
      m_idx = 0; m_pos = 0; m_rd = 0; m_coils = 0; m_next = 0;
    end else if (m_valid) begin
      wr   = bus_if.chipselect && !bus_if.write_n;
      sval = bus_if.writedata[15:0];
`ifdef STEP_POSITION_EN
      hi = m_pos;
`else
      hi = 16'd0;
`endif
      case (bus_if.address)
        2'd0: m_rd = {27'd0, m_busy, m_ctrl};
        2'd1: m_rd = {8'd0, m_period};
        2'd2: m_rd = m_rem;
        default: m_rd = {hi, 15'd0, m_done};
      endcase
      eff      = (m_period == 0) ? 1 : int'(m_period);
      step     = m_busy && (m_cyc == m_next);
      abort    = m_busy && wr && ((bus_if.address == 2'd2 && sval == 0) ||
                                  (bus_if.address == 2'd0 && !bus_if.writedata[0]));
      set_done = 0;
      if (abort) begin
        m_busy = 0;
        m_rem  = 0;
      end else if (m_busy) begin
        if (step) begin
          d = m_ctrl[2] ? 1 : 2;
          m_idx  = (m_idx + (m_ctrl[1] ? 8 - d : d)) % 8;
          m_pos  = m_ctrl[1] ? m_pos - 16'd1 : m_pos + 16'd1;
          m_rem  = m_rem - 1;
          m_next = m_cyc + eff;
        end
        if (wr && bus_if.address == 2'd2) m_rem = sval;
        if (m_rem == 0) begin
          m_busy   = 0;
          set_done = 1;
        end
      end else if (wr && bus_if.address == 2'd2) begin
        m_rem = sval;
        if (sval != 0 && m_ctrl[0]) begin
          m_busy = 1;
          m_next = m_cyc + eff;
        end
      end
      if (wr && bus_if.address == 2'd0) m_ctrl   = bus_if.writedata[3:0];
      if (wr && bus_if.address == 2'd1) m_period = bus_if.writedata[23:0];
      if (set_done) m_done = 1;
      else if (wr && bus_if.address == 2'd3) m_done = 0;
      if (wr && bus_if.address == 2'd3 && bus_if.writedata[1]) m_pos = 0;
      m_coils = m_ctrl[0] ? ph[m_idx] : 4'b0000;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_readdata", bus_if.readdata, m_rd);
      check("model_coils", {28'd0, coils}, {28'd0, m_coils});
      check("model_irq", {31'd0, irq}, {31'd0, m_done & m_ctrl[3]});
    end
  end

  // All stimulus helpers are entered and left on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_check(input string name, input logic [1:0] a,
                            input logic [31:0] mask, input logic [31:0] exp);
    bus_if.address = a;
    @(negedge clk);
    check(name, bus_if.readdata & mask, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_coils", {28'd0, coils}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus_if.address = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1;
    bus_if.writedata = '0;
    wait_cycles(3);
    reset = 1'b0;

    // Reset state: every register reads zero, coils off, no interrupt.
    check("rst_coils", {28'd0, coils}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) read_check("rst_read", 2'(a), '1, 32'd0);

    // Full-step forward, PERIOD=4, three steps.
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd3);
    check("fs_start_coils", {28'd0, coils}, 32'h1);
    read_check("fs_busy", 2'd0, '1, 32'h11);
    wait_cycles(3);
    check("fs_step1", {28'd0, coils}, 32'h2);
    wait_cycles(4);
    check("fs_step2", {28'd0, coils}, 32'h4);
    wait_cycles(4);
    check("fs_step3", {28'd0, coils}, 32'h8);
    check("fs_irq_masked", {31'd0, irq}, 32'd0);
    read_check("fs_done", 2'd3, 32'h0000FFFF, 32'h1);
    read_check("fs_not_busy", 2'd0, '1, 32'h1);

    // Reset in the middle of a move.
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd10);
    wait_cycles(4);
    pulse_reset();
    read_check("midrst_steps", 2'd2, '1, 32'd0);

    // Half-step reverse with interrupt, PERIOD=1, two steps from index 0.
    bus_write(2'd0, 32'hF);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd2);
    wait_cycles(1);
    check("hs_step1", {28'd0, coils}, 32'h9);
    wait_cycles(1);
    check("hs_step2", {28'd0, coils}, 32'h8);
    check("hs_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'd0);
    check("hs_irq_clr", {31'd0, irq}, 32'd0);

    // Long move aborted by clearing EN after five steps.
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd100);
    wait_cycles(10);
    check("en_abort_pre", {28'd0, coils}, 32'h1);
    bus_write(2'd0, 32'h0);
    check("en_abort_coils", {28'd0, coils}, 32'h0);
    read_check("en_abort_steps", 2'd2, '1, 32'd0);
    read_check("en_abort_done", 2'd3, 32'h0000FFFF, 32'd0);
    read_check("en_abort_busy", 2'd0, '1, 32'd0);

    // PERIOD=0 runs a step per clock; STATUS write on the DONE edge loses.
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd4);
    wait_cycles(3);
    bus_write(2'd3, 32'd0);
    read_check("p0_done_kept", 2'd3, 32'h0000FFFF, 32'h1);
    check("p0_coils", {28'd0, coils}, 32'h1);

    // STEPS=0 abort mid-move, then an abort colliding with the final step.
    bus_write(2'd3, 32'd0);
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd10);
    wait_cycles(4);
    bus_write(2'd2, 32'd0);
    read_check("s0_abort_done", 2'd3, 32'h0000FFFF, 32'd0);
    read_check("s0_abort_busy", 2'd0, '1, 32'h1);
    check("s0_abort_coils", {28'd0, coils}, 32'h2);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd2);
    wait_cycles(1);
    bus_write(2'd2, 32'd0);
    check("clash_coils", {28'd0, coils}, 32'h4);
    read_check("clash_done", 2'd3, 32'h0000FFFF, 32'd0);

    // Position tracking: 5 forward, 2 reverse, clear, 3 reverse.
    pulse_reset();
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd5);
    wait_cycles(5);
    bus_write(2'd0, 32'h3);
    bus_write(2'd2, 32'd2);
    wait_cycles(2);
`ifdef STEP_POSITION_EN
    read_check("pos_plus3", 2'd3, '1, 32'h0003_0001);
`else
    read_check("pos_absent", 2'd3, '1, 32'h0000_0001);
`endif
    bus_write(2'd3, 32'h2);
    read_check("pos_clear", 2'd3, '1, 32'd0);
    bus_write(2'd2, 32'd3);
    wait_cycles(3);
`ifdef STEP_POSITION_EN
    read_check("pos_minus3", 2'd3, '1, 32'hFFFD_0001);
`else
    read_check("pos_absent2", 2'd3, '1, 32'h0000_0001);
`endif

    wait_cycles(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
